// File: rtl/scr1_tcm_mp.sv
// Multi-port TCM: NUM_PORTS requesters share one single-port RAM through round-robin arbitration.
// Latency: resp/rdata one cycle after accept, two when SCR1_TCM_MP_OUTREG_EN is defined; one accept per cycle.
// Backpressure: a requester holds req and its fields until req_ack; ports that lose arbitration simply wait.
module scr1_tcm_mp #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TCM_SIZE  = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  output logic [NUM_PORTS-1:0]        req_ack,
  input  logic [NUM_PORTS-1:0]        cmd,
  input  logic [2*NUM_PORTS-1:0]      width,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [DATA_W*NUM_PORTS-1:0] wdata,
  output logic [DATA_W*NUM_PORTS-1:0] rdata,
  output logic [2*NUM_PORTS-1:0]      resp
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned DEPTH  = TCM_SIZE / LANES;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;

  typedef struct packed {
    logic              cmd;
    logic [1:0]        width;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef struct packed {
    logic              vld;
    logic [PTR_W-1:0]  port;
    logic              err;
    logic              rd;
    logic [1:0]        width;
    logic [LANE_W-1:0] lane;
  } meta_t;

  acc_t acc [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign acc[p] = {cmd[p], width[2*p +: 2], addr[ADDR_W*p +: ADDR_W], wdata[DATA_W*p +: DATA_W]};
  end

  // Round-robin: first requester at or after ptr, wrapping modulo NUM_PORTS.
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W:0]   sum;
  logic             gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_PORTS)) sum = sum - (PTR_W+1)'(NUM_PORTS);
      cand = sum[PTR_W-1:0];
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  logic accept;
  assign accept = gnt_vld & ~rst;

  always_comb begin
    req_ack = '0;
    if (accept) req_ack[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  acc_t sel;
  assign sel = acc[gnt_idx];

  logic              misalign;
  logic              oob;
  logic              err;
  logic [LANE_W-1:0] lane;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    case (sel.width)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = sel.addr[0];
      2'd2:    misalign = |sel.addr[1:0];
      default: misalign = (DATA_W != 64) || (|sel.addr[2:0]);
    endcase
  end

  assign oob  = (ADDR_W+32)'(sel.addr) >= (ADDR_W+32)'(TCM_SIZE);
  assign err  = misalign | oob;
  assign lane = sel.addr[LANE_W-1:0];
  assign idx  = sel.addr[LANE_W +: IDX_W];

  // Narrow writes are replicated across the word so the byte enables alone pick the lanes.
  logic [DATA_W-1:0] wr_dat;
  logic [LANES-1:0]  wr_be;

  always_comb begin
    wr_dat = sel.wdata;
    wr_be  = '1;
    case (sel.width)
      2'd0: begin
        for (int l = 0; l < LANES; l++) wr_dat[8*l +: 8] = sel.wdata[7:0];
        wr_be = LANES'(1) << lane;
      end
      2'd1: begin
        for (int l = 0; l < LANES/2; l++) wr_dat[16*l +: 16] = sel.wdata[15:0];
        wr_be = LANES'(3) << lane;
      end
      2'd2: begin
        for (int l = 0; l < LANES/4; l++) wr_dat[32*l +: 32] = sel.wdata[31:0];
        wr_be = LANES'(15) << lane;
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;
  logic              rd_en;

  assign wr_en = accept & sel.cmd & ~err;
  assign rd_en = accept & ~sel.cmd & ~err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
    if (rd_en) rd_word <= mem[idx];
  end

  meta_t s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.vld   <= accept;
      s1.port  <= gnt_idx;
      s1.err   <= err;
      s1.rd    <= ~sel.cmd;
      s1.width <= sel.width;
      s1.lane  <= lane;
    end
  end

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] rd_ext;

  assign shifted = rd_word >> {s1.lane, 3'b000};

  // Zero-extend; sign extension is left to the core.
  always_comb begin
    rd_ext = '0;
    if (s1.rd && !s1.err) begin
      case (s1.width)
        2'd0:    rd_ext[7:0]  = shifted[7:0];
        2'd1:    rd_ext[15:0] = shifted[15:0];
        2'd2:    rd_ext[31:0] = shifted[31:0];
        default: rd_ext       = shifted;
      endcase
    end
  end

  logic [2*NUM_PORTS-1:0]      resp_c;
  logic [DATA_W*NUM_PORTS-1:0] rdata_c;

  always_comb begin
    resp_c  = {NUM_PORTS{RESP_NOTRDY}};
    rdata_c = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (s1.vld && s1.port == PTR_W'(p)) begin
        resp_c[2*p +: 2]            = s1.err ? RESP_ER : RESP_OK;
        rdata_c[DATA_W*p +: DATA_W] = rd_ext;
      end
    end
  end

`ifdef SCR1_TCM_MP_OUTREG_EN
  logic [2*NUM_PORTS-1:0]      resp_q;
  logic [DATA_W*NUM_PORTS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      resp_q  <= resp_c;
      rdata_q <= rdata_c;
    end
  end

  // Outputs read as idle while rst is high, so a response due in a reset cycle is dropped.
  assign resp  = rst ? '0 : resp_q;
  assign rdata = rst ? '0 : rdata_q;
`else
  assign resp  = rst ? '0 : resp_c;
  assign rdata = rst ? '0 : rdata_c;
`endif

endmodule

// File: tb/tb_scr1_tcm_mp.sv
// Bench for scr1_tcm_mp (3 ports, 64-bit words, 64 KiB) against a byte-array reference model.
module tb_scr1_tcm_mp;

  localparam int NP = 3;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int unsigned TSZ = 32'h0001_0000;
`ifdef SCR1_TCM_MP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      req;
  logic [NP-1:0]      req_ack;
  logic [NP-1:0]      cmd;
  logic [2*NP-1:0]    width;
  logic [AW*NP-1:0]   addr;
  logic [DW*NP-1:0]   wdata;
  logic [DW*NP-1:0]   rdata;
  logic [2*NP-1:0]    resp;

  always #5 clk = ~clk;

  scr1_tcm_mp #(
    .NUM_PORTS(NP),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .TCM_SIZE (TSZ)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_ack(req_ack),
    .cmd    (cmd),
    .width  (width),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .resp   (resp)
  );

  typedef struct {
    bit          vld;
    int          port;
    logic [1:0]  resp;
    logic [63:0] rdata;
    int          tag;
  } exp_t;

  typedef struct {
    int          port;
    bit          cmd;
    logic [1:0]  w;
    logic [31:0] a;
    logic [63:0] wd;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rd;
  } vec_t;

  exp_t        pipe [LAT];
  logic [7:0]  mem_m [TSZ];
  int          ptr_m;
  bit          p_req [NP];
  bit          p_cmd [NP];
  logic [1:0]  p_w   [NP];
  logic [31:0] p_a   [NP];
  logic [63:0] p_wd  [NP];
  int          p_tag [NP];
  int          n_vec;
  int          n_err;
  logic [NP-1:0]    last_ack;
  logic [2*NP-1:0]  last_resp;
  logic [DW*NP-1:0] last_rdata;
  int          dut_grants[$];
  logic [1:0]  obs_resp  [32];
  logic [63:0] obs_rdata [32];
  vec_t        tab [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input bit c, input logic [1:0] w, input logic [31:0] a,
                         input logic [63:0] wd, input int tag);
    p_req[p] = 1'b1;
    p_cmd[p] = c;
    p_w[p]   = w;
    p_a[p]   = a;
    p_wd[p]  = wd;
    p_tag[p] = tag;
  endtask

  // Reference: byte-addressed memory, little-endian, natural alignment by size.
  task automatic model_access(input int g, output exp_t e);
    int unsigned sz;
    bit bad;
    sz  = 1 << p_w[g];
    bad = (p_a[g] % sz != 0) || (p_w[g] == 2'd3 && DW == 32) || (p_a[g] >= TSZ);
    e = '{vld: 1'b1, port: g, resp: (bad ? 2'd2 : 2'd1), rdata: 64'h0, tag: p_tag[g]};
    if (!bad) begin
      for (int b = 0; b < int'(sz); b++) begin
        if (p_cmd[g]) mem_m[p_a[g] + b] = p_wd[g][8*b +: 8];
        else          e.rdata[8*b +: 8] = mem_m[p_a[g] + b];
      end
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) pipe[i] = '{vld: 1'b0, port: 0, resp: 2'd0, rdata: 64'h0, tag: -1};
  endtask

  task automatic do_cycle(input bit r);
    logic [NP-1:0]    ack_e;
    logic [2*NP-1:0]  resp_e;
    logic [DW*NP-1:0] rd_e;
    int g;
    int dg;
    exp_t e;
    rst = r;
    for (int p = 0; p < NP; p++) begin
      req[p]             = p_req[p];
      cmd[p]             = p_cmd[p];
      width[2*p +: 2]    = p_w[p];
      addr[AW*p +: AW]   = p_a[p];
      wdata[DW*p +: DW]  = p_wd[p];
    end
    #1;
    last_ack   = req_ack;
    last_resp  = resp;
    last_rdata = rdata;
    resp_e = '0;
    rd_e   = '0;
    if (!r && pipe[LAT-1].vld) begin
      resp_e[2*pipe[LAT-1].port +: 2]  = pipe[LAT-1].resp;
      rd_e[DW*pipe[LAT-1].port +: DW]  = pipe[LAT-1].rdata;
      if (pipe[LAT-1].tag >= 0 && pipe[LAT-1].tag < 32) begin
        obs_resp[pipe[LAT-1].tag]  = resp[2*pipe[LAT-1].port +: 2];
        obs_rdata[pipe[LAT-1].tag] = rdata[DW*pipe[LAT-1].port +: DW];
      end
    end
    check("resp", 64'(resp), 64'(resp_e));
    for (int p = 0; p < NP; p++)
      check($sformatf("rdata%0d", p), rdata[DW*p +: DW], rd_e[DW*p +: DW]);
    g = -1;
    if (!r) begin
      for (int i = 0; i < NP; i++)
        if (g < 0 && p_req[(ptr_m + i) % NP]) g = (ptr_m + i) % NP;
    end
    ack_e = '0;
    if (g >= 0) ack_e[g] = 1'b1;
    check("req_ack", 64'(req_ack), 64'(ack_e));
    dg = -1;
    for (int p = 0; p < NP; p++) if (req_ack[p]) dg = p;
    if (!r && dg >= 0) dut_grants.push_back(dg);
    e = '{vld: 1'b0, port: 0, resp: 2'd0, rdata: 64'h0, tag: -1};
    if (g >= 0) begin
      model_access(g, e);
      ptr_m    = (g + 1) % NP;
      p_req[g] = 1'b0;
    end
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = e;
    if (r) begin
      clear_pipe();
      ptr_m = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int p = 0; p < NP; p++) p_req[p] = 1'b0;
    repeat (LAT + 1) do_cycle(1'b0);
  endtask

  initial begin
    tab[0]  = '{0, 1'b1, 2'd2, 32'h100,   64'hDEADBEEF,         2'd1, 64'h0};
    tab[1]  = '{0, 1'b0, 2'd2, 32'h100,   64'h0,                2'd1, 64'hDEADBEEF};
    tab[2]  = '{1, 1'b1, 2'd0, 32'h101,   64'h5A,               2'd1, 64'h0};
    tab[3]  = '{2, 1'b0, 2'd2, 32'h100,   64'h0,                2'd1, 64'hDEAD5AEF};
    tab[4]  = '{0, 1'b0, 2'd0, 32'h101,   64'h0,                2'd1, 64'h5A};
    tab[5]  = '{1, 1'b0, 2'd1, 32'h103,   64'h0,                2'd2, 64'h0};
    tab[6]  = '{2, 1'b0, 2'd2, 32'h10000, 64'h0,                2'd2, 64'h0};
    tab[7]  = '{0, 1'b0, 2'd2, 32'h100,   64'h0,                2'd1, 64'hDEAD5AEF};
    tab[8]  = '{1, 1'b1, 2'd3, 32'h8,     64'h0123456789ABCDEF, 2'd1, 64'h0};
    tab[9]  = '{2, 1'b0, 2'd2, 32'hC,     64'h0,                2'd1, 64'h01234567};
    tab[10] = '{0, 1'b0, 2'd3, 32'h4,     64'h0,                2'd2, 64'h0};
    tab[11] = '{1, 1'b0, 2'd3, 32'h8,     64'h0,                2'd1, 64'h0123456789ABCDEF};
    tab[12] = '{2, 1'b1, 2'd1, 32'h10A,   64'hFFFF1234,         2'd1, 64'h0};
    tab[13] = '{0, 1'b0, 2'd1, 32'h10A,   64'h0,                2'd1, 64'h1234};
    tab[14] = '{1, 1'b1, 2'd2, 32'h10001, 64'h77777777,         2'd2, 64'h0};

    n_vec = 0;
    n_err = 0;
    ptr_m = 0;
    for (int p = 0; p < NP; p++) begin
      p_req[p] = 1'b0; p_cmd[p] = 1'b0; p_w[p] = 2'd0;
      p_a[p] = '0; p_wd[p] = '0; p_tag[p] = -1;
    end
    for (int i = 0; i < 32; i++) begin
      obs_resp[i]  = 2'd3;
      obs_rdata[i] = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    clear_pipe();
    rst = 1'b1; req = '0; cmd = '0; width = '0; addr = '0; wdata = '0;
    @(posedge clk);
    #1;
    do_cycle(1'b1);
    do_cycle(1'b1);
    do_cycle(1'b0);
    check("reset_resp", 64'(last_resp), 64'h0);
    check("reset_rdata0", last_rdata[DW-1:0], 64'h0);

    // Preload the low 512 bytes so later reads see defined data.
    for (int i = 0; i < 64; i++) begin
      set_req(0, 1'b1, 2'd3, 32'(i * 8), {$urandom, $urandom}, -1);
      do_cycle(1'b0);
    end
    drain();

    // Directed vectors issued back to back, responses captured by tag.
    for (int i = 0; i < 15; i++) begin
      set_req(tab[i].port, tab[i].cmd, tab[i].w, tab[i].a, tab[i].wd, i);
      do_cycle(1'b0);
    end
    drain();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("tab%0d_resp", i), 64'(obs_resp[i]), 64'(tab[i].exp_resp));
      check($sformatf("tab%0d_rdata", i), obs_rdata[i], tab[i].exp_rd);
    end

    // All three ports requesting continuously after reset: grants 0,1,2,0,1,2.
    do_cycle(1'b1);
    dut_grants.delete();
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < NP; p++)
        if (!p_req[p]) set_req(p, 1'b0, 2'd2, 32'(32'h40 + 8 * p), 64'h0, -1);
      do_cycle(1'b0);
    end
    drain();
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_grant%0d", i), 64'(dut_grants.size() > i ? dut_grants[i] : -1), 64'(i % 3));

    // Reset in the cycle after an accepted read, with a write presented during reset.
    set_req(0, 1'b1, 2'd2, 32'h180, 64'hA5A5A5A5, -1);
    do_cycle(1'b0);
    drain();
    set_req(1, 1'b0, 2'd2, 32'h180, 64'h0, -1);
    do_cycle(1'b0);
    set_req(2, 1'b1, 2'd2, 32'h180, 64'h11111111, -1);
    do_cycle(1'b1);
    check("rst_ack", 64'(last_ack), 64'h0);
    check("rst_resp", 64'(last_resp), 64'h0);
    check("rst_rdata1", last_rdata[DW*1 +: DW], 64'h0);
    p_req[2] = 1'b0;
    dut_grants.delete();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 2'd2, 32'h180, 64'h0, 20 + p);
    repeat (3) do_cycle(1'b0);
    drain();
    check("rst_ptr", 64'(dut_grants.size() > 0 ? dut_grants[0] : -1), 64'h0);
    check("rst_nowrite_resp", 64'(obs_resp[20]), 64'h1);
    check("rst_nowrite_data", obs_rdata[20], 64'hA5A5A5A5);

    // Random traffic with occasional errors and resets.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!p_req[p] && $urandom_range(0, 1) == 1) begin
          logic [1:0]  w;
          logic [31:0] a;
          int          k;
          w = 2'($urandom_range(0, 3));
          k = $urandom_range(0, 19);
          if (k == 0)      a = TSZ + 32'($urandom_range(0, 7) * 8);
          else if (k == 1) a = 32'($urandom_range(0, 511));
          else             a = 32'($urandom_range(0, 511)) & ~((32'd1 << w) - 32'd1);
          set_req(p, 1'($urandom_range(0, 1)), w, a, {$urandom, $urandom}, -1);
        end
      end
      do_cycle($urandom_range(0, 199) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_mp.md
Name: scr1_tcm_mp

Overview:
- Parametrised multi-port tightly-coupled memory for SCR1-class cores: NUM_PORTS requesters share one single-port RAM array.
- Successor to the fixed imem/dmem shared-port TCM. Generalised in data width, depth and port count.
- Adds round-robin arbitration, a pipelined one-access-per-cycle handshake, and an error response for misaligned or out-of-range accesses.
- Sits between the core memory routers and the on-chip RAM.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..4); port 0 is normally imem.
- DATA_W, 32, memory word width in bits (32 or 64).
- ADDR_W, 32, request address width in bits.
- TCM_SIZE, 32'h00010000, memory size in bytes; power of two, at least DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_PORTS  request valid, one bit per port
- req_ack  out  NUM_PORTS  request accepted this cycle (one-hot or zero)
- cmd  in  NUM_PORTS  per port: 0=read, 1=write
- width  in  2*NUM_PORTS  per port: 0=byte, 1=hword, 2=word, 3=dword (legal only when DATA_W=64)
- addr  in  ADDR_W*NUM_PORTS  per-port byte address
- wdata  in  DATA_W*NUM_PORTS  per-port write data, LSB-aligned
- rdata  out  DATA_W*NUM_PORTS  per-port read data, LSB-aligned
- resp  out  2*NUM_PORTS  per port: 0=NOTRDY, 1=RDY_OK, 2=RDY_ER

Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset: req_ack=0, all resp=NOTRDY, all rdata=0, round-robin pointer=0, pending response cleared. RAM contents are not reset.
- Reset asserted mid-operation: any response due next cycle is dropped; no write is performed in a cycle where rst=1.
- Arbitration is combinational each cycle:
  - Grant the first requesting port at or after the pointer, wrapping modulo NUM_PORTS.
  - req_ack is asserted only for the granted port.
  - On a grant to port g, the pointer becomes (g+1) mod NUM_PORTS at the next clock. With no requests, the pointer holds.
- Handshake:
  - A transfer is accepted when req & req_ack is high at the clock edge.
  - A requester holds req/cmd/width/addr/wdata stable until acked.
  - One access is accepted per cycle; back-to-back accepts are allowed.
- Latency: for an access accepted in cycle N, that port's resp is RDY_OK or RDY_ER during cycle N+1 only. All other ports show NOTRDY in N+1.
- Errors (RDY_ER, no RAM write, rdata=0):
  - width not naturally aligned: hword with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - width=3 when DATA_W=32.
  - addr >= TCM_SIZE.
- Write path:
  - Lane count L=DATA_W/8; lane index = addr[log2(L)-1:0].
  - wdata is replicated across lanes: byte L times, hword L/2 times, word L/4 times.
  - Byte enables are set for the addressed lanes only; bytes outside them are unchanged.
  - A write response carries rdata=0.
- Read path:
  - The RAM word at addr[log2(TCM_SIZE)-1:log2(L)] is read.
  - The registered lane index is used to shift right by 8*lane.
  - Upper bits beyond the access width are zero-extended (no sign extension; the core does that).
- Simultaneous read and write from different ports: serialised by arbitration. A read granted after a write to the same address returns the new data.

Optional Feature:
- SCR1_TCM_MP_OUTREG_EN defined: an extra output register stage is added.
  - resp and rdata appear in cycle N+2 instead of N+1.
  - Throughput is still one access per cycle.
  - Reset clears both pipeline stages.
- Undefined: single-stage timing as above.

Test Plan:
- Reset, then port0 writes word 32'hDEADBEEF to 0x100 and port0 reads 0x100 one cycle later -> write resp RDY_OK at N+1; read resp RDY_OK with rdata=32'hDEADBEEF at N+2.
- Byte write 8'h5A to 0x101 over 32'hDEADBEEF, then read word 0x100 -> 32'hDEAD5AEF; byte read 0x101 -> 32'h0000005A.
- NUM_PORTS=3, all ports request continuously for 6 cycles -> grants 0,1,2,0,1,2, each resp one cycle after its grant.
- Hword read at 0x103 and word read at 0x0001_0000 (TCM_SIZE=64KiB) -> RDY_ER with rdata=0; memory unchanged on a follow-up read.
- DATA_W=64: dword write 64'h0123456789ABCDEF to 0x8, then word read 0xC -> 32'h01234567; dword read at 0x4 -> RDY_ER.
- rst asserted in the cycle after an accepted read -> resp NOTRDY, rdata=0, pointer=0; a write accepted in the same cycle as rst does not modify memory.
